// File: rtl/qshift_fifo_fwft.sv
// First-word-fall-through FIFO: non-reset shift-register storage feeding one
// registered head stage, with occupancy count, programmable flags and error pulses.
module qshift_fifo_fwft #(
  parameter int FIFO_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 16,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int PROG_EMPTY_THRESH = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [FIFO_WIDTH-1:0] i_din,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  output logic [FIFO_WIDTH-1:0] o_dout,
  output logic                  o_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_prog_full,
  output logic                  o_prog_empty,
  output logic [CW-1:0]         o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int SD = FIFO_DEPTH - 1;
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PF_C   = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_C   = CW'(PROG_EMPTY_THRESH);
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("qshift_fifo_fwft: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256) begin : g_bad_depth
    $error("qshift_fifo_fwft: FIFO_DEPTH must be 2..256");
  end
  if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > FIFO_DEPTH) begin : g_bad_pf
    $error("qshift_fifo_fwft: PROG_FULL_THRESH must be 1..FIFO_DEPTH");
  end
  if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_pe
    $error("qshift_fifo_fwft: PROG_EMPTY_THRESH must be 0..FIFO_DEPTH-1");
  end

  logic [FIFO_WIDTH-1:0] mem_r [SD];
  logic [FIFO_WIDTH-1:0] dout_r;
  logic                  valid_r;
  logic [CW-1:0]         count_r;
  logic                  full_r;
  logic                  prog_full_r;
  logic                  prog_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic [CW-1:0]         s_cnt_s;
  logic [CW-1:0]         s_last_s;
  logic                  bypass_s;
  logic                  load_s;
  logic                  shift_s;
  logic [AW-1:0]         rd_addr_s;
  logic [CW-1:0]         count_nxt_s;

  // Accept decode, head-stage load decision and next occupancy
  always_comb begin
    rd_acc_s    = i_rd_en & valid_r;
    wr_acc_s    = i_wr_en & (~full_r | rd_acc_s);
    s_cnt_s     = count_r - {{(CW-1){1'b0}}, valid_r};
    s_last_s    = s_cnt_s - ONE_C;
    bypass_s    = (s_cnt_s == {CW{1'b0}});
    load_s      = (~valid_r | rd_acc_s) & (~bypass_s | wr_acc_s);
    // A bypassed write goes straight to the head and never touches storage
    shift_s     = wr_acc_s & ~(load_s & bypass_s);
    count_nxt_s = count_r + {{(CW-1){1'b0}}, wr_acc_s} - {{(CW-1){1'b0}}, rd_acc_s};
    if (bypass_s) begin
      rd_addr_s = {AW{1'b0}};
    end else begin
      rd_addr_s = s_last_s[AW-1:0];
    end
  end

  // Storage shift array, intentionally not reset so it maps onto SRL primitives
  always_ff @(posedge i_clk) begin
    if (shift_s) begin
      for (int i = SD - 1; i > 0; i--) begin
        mem_r[i] <= mem_r[i-1];
      end
      mem_r[0] <= i_din;
    end
  end

  // Head stage, occupancy, flags and error pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout_r       <= {FIFO_WIDTH{1'b0}};
      valid_r      <= 1'b0;
      count_r      <= {CW{1'b0}};
      full_r       <= 1'b0;
      prog_full_r  <= 1'b0;
      prog_empty_r <= 1'b1;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      if (load_s) begin
        dout_r <= bypass_s ? i_din : mem_r[rd_addr_s];
      end
      valid_r      <= load_s | (valid_r & ~rd_acc_s);
      count_r      <= count_nxt_s;
      full_r       <= (count_nxt_s == FULL_C);
      prog_full_r  <= (count_nxt_s >= PF_C);
      prog_empty_r <= (count_nxt_s <= PE_C);
      overflow_r   <= i_wr_en & full_r & ~rd_acc_s;
      underflow_r  <= i_rd_en & ~valid_r;
    end
  end

  assign o_dout       = dout_r;
  assign o_valid      = valid_r;
  assign o_empty      = ~valid_r;
  assign o_full       = full_r;
  assign o_prog_full  = prog_full_r;
  assign o_prog_empty = prog_empty_r;
  assign o_count      = count_r;
  assign o_overflow   = overflow_r;
  assign o_underflow  = underflow_r;

endmodule

// File: tb/tb_qshift_fifo_fwft.sv
// Bench for qshift_fifo_fwft: directed scenarios plus random traffic, all checked
// against a queue-based model of an ideal first-word-fall-through FIFO.
module tb_qshift_fifo_fwft;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int PF = 3;
  localparam int PE = 1;
  localparam int CW = $clog2(D + 1);

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [W-1:0]  i_din;
  logic          i_wr_en;
  logic          i_rd_en;
  logic [W-1:0]  o_dout;
  logic          o_valid;
  logic          o_empty;
  logic          o_full;
  logic          o_prog_full;
  logic          o_prog_empty;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] model_q [$];

  qshift_fifo_fwft #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D),
    .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_din(i_din),
    .i_wr_en(i_wr_en), .i_rd_en(i_rd_en), .o_dout(o_dout),
    .o_valid(o_valid), .o_empty(o_empty), .o_full(o_full),
    .o_prog_full(o_prog_full), .o_prog_empty(o_prog_empty),
    .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    if (obs === exp_v) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_state(input logic ov_exp, input logic uf_exp);
    int n;
    n = model_q.size();
    check("valid", 32'(o_valid), 32'(n != 0));
    check("empty", 32'(o_empty), 32'(n == 0));
    if (n != 0) check("dout", 32'(o_dout), 32'(model_q[0]));
    check("count", 32'(o_count), 32'(n));
    check("full", 32'(o_full), 32'(n == D));
    check("prog_full", 32'(o_prog_full), 32'(n >= PF));
    check("prog_empty", 32'(o_prog_empty), 32'(n <= PE));
    check("overflow", 32'(o_overflow), 32'(ov_exp));
    check("underflow", 32'(o_underflow), 32'(uf_exp));
  endtask

  // One clock of traffic: model decides acceptance from its own occupancy
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] d);
    bit rd_acc, wr_acc, ov, uf;
    logic [W-1:0] junk;
    i_wr_en = wr; i_rd_en = rd; i_din = d;
    rd_acc = rd && (model_q.size() > 0);
    wr_acc = wr && ((model_q.size() < D) || rd_acc);
    ov = wr && (model_q.size() == D) && !rd_acc;
    uf = rd && (model_q.size() == 0);
    if (rd_acc) junk = model_q.pop_front();
    if (wr_acc) model_q.push_back(d);
    @(posedge i_clk); #1;
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    check_state(ov, uf);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  initial begin
    i_din = '0; i_wr_en = 1'b0; i_rd_en = 1'b0;
    do_reset();
    check("rst_dout", 32'(o_dout), 32'h0);
    check_state(1'b0, 1'b0);

    // 1: latency of a write into an empty FIFO
    step(1'b1, 1'b0, 8'hA1);
    check("t1_dout", 32'(o_dout), 32'hA1);
    check("t1_count", 32'(o_count), 32'd1);
    step(1'b0, 1'b1, 8'h00);

    // 2: fill, overflow, drain
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
    check("t2_full", 32'(o_full), 32'd1);
    step(1'b1, 1'b0, 8'h05);
    check("t2_overflow", 32'(o_overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t2_read", 32'(o_dout), 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end

    // 3: simultaneous rd+wr while full
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
    for (int i = 5; i <= 8; i++) begin
      check("t3_pop", 32'(o_dout), 32'(i - 4));
      step(1'b1, 1'b1, 8'(i));
      check("t3_full", 32'(o_full), 32'd1);
    end
    for (int i = 5; i <= 8; i++) begin
      check("t3_drain", 32'(o_dout), 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end

    // 4: underflow
    step(1'b0, 1'b1, 8'h00);
    check("t4_underflow", 32'(o_underflow), 32'd1);

    // 5: streaming at count=1
    step(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < 20; i++) begin
      check("t5_stream", 32'(o_dout), 32'(8'h10 + i));
      step(1'b1, 1'b1, 8'(8'h11 + i));
    end
    step(1'b0, 1'b1, 8'h00);

    // 6: asynchronous reset mid-cycle with entries present
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    #2 i_rst_n = 1'b0;
    #1;
    model_q.delete();
    check("t6_rst_dout", 32'(o_dout), 32'h0);
    check_state(1'b0, 1'b0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    step(1'b1, 1'b0, 8'h5A);
    check("t6_readback", 32'(o_dout), 32'h5A);
    step(1'b0, 1'b1, 8'h00);

    // Random traffic with alternating write/read bias
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 30;
      step(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < (100 - wp)),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
